mmio_uart_tx: RTL

- Memory-mapped UART transmitter on the core's data port, in parallel with data_memory.
- Decodes ram_addr against BASE_ADDR, accepts byte writes into a TX FIFO, and serialises them 8N1 on `tx`.
- Provides status and baud-divider registers for polled firmware output (console/debug print).
- The top muxes `dout` onto Rd_mem_data when `sel` is high.

---
 rtl/mmio_uart_tx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO, status and baud-divider registers
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        W_en,
    input  logic        R_en,
    input  logic [31:0] addr,
    input  logic [2:0]  RW_type,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        sel,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   baud_q, baud_d;
    logic [1:0]    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d, lim_q, lim_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [1:0]    off;
    logic          wr, push_req, push_ok, pop, full, empty, busy, tick;
    logic [31:0]   status;
    logic          unused;

    assign sel      = addr[31:4] == BASE_ADDR[31:4];
    assign off      = addr[3:2];
    assign wr       = sel && W_en;
    assign push_req = wr && off == 2'd0;
    assign full     = count_q == CW'(FIFO_DEPTH);
    assign empty    = count_q == '0;
    assign busy     = state_q != S_IDLE;
    assign tick     = cnt_q == lim_q;
    assign pop      = !empty && (state_q == S_IDLE || (state_q == S_STOP && tick));
    assign push_ok  = push_req && (!full || pop);
    assign status   = {20'h0, 4'(count_q), 4'h0, ovf_q, empty, full, busy};
    assign tx       = tx_q;
    assign unused   = ^{RW_type, din[31:16], addr[1:0]};

    // Register read mux; reads have no side effects so a same-cycle write is seen next cycle
    always_comb begin
        dout = !(sel && R_en) ? 32'h0 :
               off == 2'd1    ? status :
               off == 2'd2    ? {16'h0, baud_q} : 32'h0;
    end

    // FIFO pointers, occupancy, sticky overflow (set beats clear) and baud register updates
    always_comb begin
        wptr_d  = wptr_q + AW'(push_ok);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + CW'(push_ok) - CW'(pop);
        ovf_d   = (push_req && full && !pop) ? 1'b1 :
                  (wr && off == 2'd1 && din[3]) ? 1'b0 : ovf_q;
        baud_d  = (wr && off == 2'd2) ? din[15:0] : baud_q;
    end

    // Transmit FSM: a pop loads the shifter and latches the divider for the whole frame
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? 16'd0 : cnt_q + 16'd1;
        lim_d   = lim_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (pop) begin
            state_d = S_START;
            cnt_d   = 16'd0;
            lim_d   = baud_q;
            shift_d = mem_q[rptr_q];
            tx_d    = 1'b0;
        end else begin
            case (state_q)
                S_START: if (tick) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
                S_DATA: if (tick) begin
                    state_d = bit_q == 3'd7 ? S_STOP : S_DATA;
                    bit_d   = bit_q + 3'd1;
                    shift_d = shift_q >> 1;
                    tx_d    = bit_q == 3'd7 ? 1'b1 : shift_q[1];
                end
                S_STOP: if (tick) state_d = S_IDLE;
                default: cnt_d = 16'd0;
            endcase
        end
    end

    // FIFO storage needs no reset; emptiness is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din[7:0];
    end

    // State registers with asynchronous reset to an idle, empty transmitter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            baud_q  <= DEFAULT_DIV;
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            lim_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            baud_q  <= baud_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end
endmodule
